// File: rtl/polaris_bus_arbiter.sv
// Two-master (instruction / data) to single-slave bus arbiter with alternating
// priority on contention, direct hand-over on acknowledge, and a no-ack timeout.
module polaris_bus_arbiter #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic        iack_o,
    output logic [31:0] idat_o,
    output logic        ierr_o,

    input  logic [63:0] dadr_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dwe_i,
    input  logic [63:0] ddat_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic        derr_o,

    output logic [63:0] xadr_o,
    output logic [1:0]  xsiz_o,
    output logic        xwe_o,
    output logic [63:0] xdat_o,
    input  logic [63:0] xdat_i,
    input  logic        xack_i,

    output logic [1:0]  gnt_o
);

    // State encoding doubles as the gnt_o diagnostic value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t     state_q, state_d;
    logic       last_d_q, last_d_d;     // 1: D master owned the bus last
    logic [7:0] cnt_q, cnt_d;
    logic       ireq, dreq;
    logic       tmo_hit;

    assign ireq = (isiz_i != 2'b00);
    assign dreq = (dsiz_i != 2'b00);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    // Priority inside a grant: ack, then owner withdrawal, then timeout.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = 8'd0;
        tmo_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ireq && dreq) begin
                    state_d = last_d_q ? IGNT : DGNT;
                end else if (ireq) begin
                    state_d = IGNT;
                end else if (dreq) begin
                    state_d = DGNT;
                end
            end
            IGNT: begin
                if (xack_i) begin
                    last_d_d = 1'b0;
                    if (dreq) begin
                        state_d = DGNT;
                    end else if (ireq) begin
                        state_d = IGNT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!ireq) begin
                    last_d_d = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    last_d_d = 1'b0;
                    tmo_hit  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DGNT: begin
                if (xack_i) begin
                    last_d_d = 1'b1;
                    if (ireq) begin
                        state_d = IGNT;
                    end else if (dreq) begin
                        state_d = DGNT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!dreq) begin
                    last_d_d = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    last_d_d = 1'b1;
                    tmo_hit  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux is purely combinational from the registered owner, so an
    // asynchronous reset silences the slave side in the same cycle.
    always_comb begin
        xadr_o = 64'd0;
        xsiz_o = 2'b00;
        xwe_o  = 1'b0;
        xdat_o = 64'd0;
        iack_o = 1'b0;
        idat_o = 32'd0;
        ierr_o = 1'b0;
        dack_o = 1'b0;
        ddat_o = 64'd0;
        derr_o = 1'b0;
        gnt_o  = state_q;
        unique case (state_q)
            IGNT: begin
                xadr_o = iadr_i;
                xsiz_o = isiz_i;
                iack_o = xack_i;
                idat_o = iadr_i[2] ? xdat_i[63:32] : xdat_i[31:0];
                ierr_o = tmo_hit;
            end
            DGNT: begin
                xadr_o = dadr_i;
                xsiz_o = dsiz_i;
                xwe_o  = dwe_i;
                xdat_o = ddat_i;
                dack_o = xack_i;
                ddat_o = xdat_i;
                derr_o = tmo_hit;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Directed bench for polaris_bus_arbiter with a short timeout (TMO_CYCLES=4).
module tb_polaris_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic        ierr_o;
    logic [63:0] dadr_i;
    logic [1:0]  dsiz_i;
    logic        dwe_i;
    logic [63:0] ddat_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic        derr_o;
    logic [63:0] xadr_o;
    logic [1:0]  xsiz_o;
    logic        xwe_o;
    logic [63:0] xdat_o;
    logic [63:0] xdat_i;
    logic        xack_i;
    logic [1:0]  gnt_o;

    int errors = 0;
    int checks = 0;

    polaris_bus_arbiter #(.TMO_CYCLES(4)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .iadr_i (iadr_i),
        .isiz_i (isiz_i),
        .iack_o (iack_o),
        .idat_o (idat_o),
        .ierr_o (ierr_o),
        .dadr_i (dadr_i),
        .dsiz_i (dsiz_i),
        .dwe_i  (dwe_i),
        .ddat_i (ddat_i),
        .dack_o (dack_o),
        .ddat_o (ddat_o),
        .derr_o (derr_o),
        .xadr_o (xadr_o),
        .xsiz_o (xsiz_o),
        .xwe_o  (xwe_o),
        .xdat_o (xdat_o),
        .xdat_i (xdat_i),
        .xack_i (xack_i),
        .gnt_o  (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b0;
        iadr_i = 64'd0; isiz_i = 2'b00;
        dadr_i = 64'd0; dsiz_i = 2'b00; dwe_i = 1'b0; ddat_i = 64'd0;
        xdat_i = 64'd0; xack_i = 1'b0;
        tick();
        tick();

        // Request already present while in reset: everything stays quiet.
        isiz_i = 2'b10; iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_xsiz", xsiz_o, 2'b00);
        chk("rst_xadr", xadr_o, 64'd0);
        chk("rst_iack", iack_o, 1'b0);
        chk("rst_dack", dack_o, 1'b0);
        chk("rst_err", {ierr_o, derr_o}, 2'b00);

        reset_i = 1'b1;
        #1;
        chk("rel_gnt", gnt_o, 2'b00);
        chk("rel_xadr", xadr_o, 64'd0);

        tick();
        #1;
        chk("i_gnt", gnt_o, 2'b01);
        chk("i_xadr", xadr_o, 64'hFFFF_FFFF_FFFF_FF00);
        chk("i_xsiz", xsiz_o, 2'b10);
        chk("i_xwe", xwe_o, 1'b0);
        chk("i_xdat", xdat_o, 64'd0);
        chk("i_iack_pre", iack_o, 1'b0);

        xack_i = 1'b1; xdat_i = 64'h0000_0013_CAFE_F00D;
        #1;
        chk("i_iack", iack_o, 1'b1);
        chk("i_idat_lo", idat_o, 32'hCAFE_F00D);
        chk("i_dack", dack_o, 1'b0);
        chk("i_ddat", ddat_o, 64'd0);
        iadr_i = 64'hFFFF_FFFF_FFFF_FF04;
        #1;
        chk("i_idat_hi", idat_o, 32'h0000_0013);
        chk("i_xadr_pass", xadr_o, 64'hFFFF_FFFF_FFFF_FF04);
        isiz_i = 2'b00;
        #1;
        chk("i_xsiz_pass", xsiz_o, 2'b00);

        tick();
        #1;
        chk("idle_gnt", gnt_o, 2'b00);
        chk("idle_ack_ignored", iack_o, 1'b0);
        chk("idle_idat", idat_o, 32'd0);
        xack_i = 1'b0;

        // Owner withdraws without ack: silent abort.
        isiz_i = 2'b01; iadr_i = 64'h40;
        tick();
        #1;
        chk("ab_gnt", gnt_o, 2'b01);
        isiz_i = 2'b00;
        #1;
        chk("ab_iack", iack_o, 1'b0);
        tick();
        #1;
        chk("ab_idle", gnt_o, 2'b00);
        chk("ab_ierr", ierr_o, 1'b0);

        // Simultaneous requests with last owner I: D first, then direct hand-over.
        isiz_i = 2'b01; iadr_i = 64'h100;
        dsiz_i = 2'b11; dadr_i = 64'h200; dwe_i = 1'b0;
        #1;
        chk("both_idle_gnt", gnt_o, 2'b00);
        chk("both_idle_xsiz", xsiz_o, 2'b00);
        tick();
        #1;
        chk("both_d_gnt", gnt_o, 2'b10);
        chk("both_d_xadr", xadr_o, 64'h200);
        chk("both_d_xsiz", xsiz_o, 2'b11);
        xack_i = 1'b1; xdat_i = 64'h1111_2222_3333_4444;
        #1;
        chk("both_dack", dack_o, 1'b1);
        chk("both_ddat", ddat_o, 64'h1111_2222_3333_4444);
        chk("both_iack0", iack_o, 1'b0);
        chk("both_idat0", idat_o, 32'd0);
        tick();
        xack_i = 1'b0;
        #1;
        chk("hand_i_gnt", gnt_o, 2'b01);
        chk("hand_i_xadr", xadr_o, 64'h100);
        chk("hand_i_xsiz", xsiz_o, 2'b01);
        xack_i = 1'b1; isiz_i = 2'b00; dsiz_i = 2'b00;
        #1;
        chk("hand_iack", iack_o, 1'b1);
        tick();
        xack_i = 1'b0;
        isiz_i = 2'b01; dsiz_i = 2'b11;
        #1;
        chk("again_idle", gnt_o, 2'b00);
        tick();
        #1;
        chk("again_d_gnt", gnt_o, 2'b10);

        // D write
        isiz_i = 2'b00;
        dadr_i = 64'h124; dwe_i = 1'b1; ddat_i = 64'h1234;
        #1;
        chk("wr_xwe", xwe_o, 1'b1);
        chk("wr_xdat", xdat_o, 64'h1234);
        chk("wr_xadr", xadr_o, 64'h124);
        chk("wr_iack0", iack_o, 1'b0);
        tick();
        xack_i = 1'b1;
        #1;
        chk("wr_dack", dack_o, 1'b1);
        chk("wr_iack1", iack_o, 1'b0);
        chk("wr_derr", derr_o, 1'b0);
        dsiz_i = 2'b00; dwe_i = 1'b0;
        tick();
        xack_i = 1'b0;
        #1;
        chk("wr_idle", gnt_o, 2'b00);
        chk("wr_idle_xwe", xwe_o, 1'b0);
        chk("wr_idle_xdat", xdat_o, 64'd0);

        // Timeout after four unacknowledged grant cycles.
        dsiz_i = 2'b01; dadr_i = 64'h300;
        tick();
        #1;
        chk("tmo_c1_gnt", gnt_o, 2'b10);
        chk("tmo_c1_derr", derr_o, 1'b0);
        tick();
        tick();
        #1;
        chk("tmo_c3_derr", derr_o, 1'b0);
        tick();
        #1;
        chk("tmo_c4_derr", derr_o, 1'b1);
        chk("tmo_c4_dack", dack_o, 1'b0);
        chk("tmo_c4_ierr", ierr_o, 1'b0);
        tick();
        #1;
        chk("tmo_after_gnt", gnt_o, 2'b00);
        chk("tmo_after_derr", derr_o, 1'b0);

        // Ack on the would-be timeout cycle wins.
        tick();
        tick();
        tick();
        tick();
        xack_i = 1'b1; dsiz_i = 2'b00;
        #1;
        chk("race_gnt", gnt_o, 2'b10);
        chk("race_dack", dack_o, 1'b1);
        chk("race_derr", derr_o, 1'b0);
        tick();
        xack_i = 1'b0;
        #1;
        chk("race_idle", gnt_o, 2'b00);

        // Reset in the middle of a D transfer.
        dsiz_i = 2'b10; dadr_i = 64'h500;
        tick();
        #1;
        chk("mr_gnt", gnt_o, 2'b10);
        xack_i = 1'b1;
        reset_i = 1'b0;
        #1;
        chk("mr_xsiz", xsiz_o, 2'b00);
        chk("mr_gnt0", gnt_o, 2'b00);
        chk("mr_dack", dack_o, 1'b0);
        chk("mr_xadr", xadr_o, 64'd0);
        chk("mr_derr", derr_o, 1'b0);
        tick();
        xack_i = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("mr_rel_gnt", gnt_o, 2'b00);
        tick();
        #1;
        chk("mr_regnt", gnt_o, 2'b10);
        chk("mr_regnt_xsiz", xsiz_o, 2'b10);
        dsiz_i = 2'b00;
        tick();
        #1;
        chk("mr_end_idle", gnt_o, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
